audio_out_feeder: RTL and testbench

AUDIO_OUT_FEEDER -- requirements
Module: audio_out_feeder

---
 rtl/audio_pkg.sv | 6 +
 rtl/sample_fifo.sv | 38 +++
 rtl/audio_out_feeder.sv | 49 ++++
 tb/tb_audio_out_feeder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared defaults and FSM encoding for the audio output feeder.
package audio_pkg;
  localparam int SAMPLE_W_DEF = 32;
  localparam int FIFO_DEPTH_DEF = 4;
  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: power-of-two circular sample buffer; a push while full succeeds only alongside a pop.
module sample_fifo import audio_pkg::*; #(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int W = SAMPLE_W_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = level == '0;
  assign full = level == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/audio_out_feeder.sv
// audio_out_feeder: converts, attenuates and queues mixer samples, then paces them into the codec.
module audio_out_feeder import audio_pkg::*; #(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [SAMPLE_W-1:0]           mix_down,
  input  logic                          sample_tick,
  input  logic [1:0]                    volume,
  input  logic                          mute,
  input  logic                          audio_out_allowed,
  output logic [SAMPLE_W-1:0]           left_channel_audio_out,
  output logic [SAMPLE_W-1:0]           right_channel_audio_out,
  output logic                          write_audio_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  state_t state, next_state;
  logic [SAMPLE_W-1:0] conv, processed, head, sample_q;
  logic signed [SAMPLE_W-1:0] shifted;
  logic pop, full, empty;
  // Offset-binary to two's complement is just an MSB flip; kept in a signed net so >>> sign-extends.
  assign conv = {~mix_down[SAMPLE_W-1], mix_down[SAMPLE_W-2:0]};
  assign shifted = $signed(conv) >>> volume;
  assign processed = mute ? '0 : shifted;
  sample_fifo #(.DEPTH(FIFO_DEPTH), .W(SAMPLE_W)) u_fifo (
    .clk(clk), .resetn(resetn), .push(sample_tick), .pop(pop), .din(processed),
    .dout(head), .full(full), .empty(empty), .level(fifo_level)
  );
  always_comb begin
    pop = state == IDLE && !empty && audio_out_allowed;
    next_state = pop ? WRITE : state == WRITE ? GAP : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      sample_q <= '0;
      overflow <= 1'b0;
    end else begin
      state <= next_state;
      if (pop) sample_q <= head;
      if (sample_tick && full && !pop) overflow <= 1'b1;
    end
  end
  assign write_audio_out = state == WRITE;
  assign left_channel_audio_out = sample_q;
  assign right_channel_audio_out = sample_q;
endmodule

// File: tb/tb_audio_out_feeder.sv
// tb_audio_out_feeder: directed vector table plus hand-written multi-cycle sequences.
module tb_audio_out_feeder;
  logic clk, resetn, sample_tick, mute, audio_out_allowed;
  logic [31:0] mix_down;
  logic [1:0] volume;
  logic [31:0] left, right;
  logic write_audio_out, overflow;
  logic [2:0] fifo_level;
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] mix;
    logic [1:0]  vol;
    logic        mute;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [8];

  audio_out_feeder dut (
    .clk(clk), .resetn(resetn), .mix_down(mix_down), .sample_tick(sample_tick),
    .volume(volume), .mute(mute), .audio_out_allowed(audio_out_allowed),
    .left_channel_audio_out(left), .right_channel_audio_out(right),
    .write_audio_out(write_audio_out), .fifo_level(fifo_level), .overflow(overflow)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 0;
    sample_tick = 0;
    step();
    step();
    resetn = 1;
  endtask

  // Current cycle must be the write strobe; walks through GAP and IDLE.
  task automatic expect_write(input logic [31:0] exp);
    chk("write_strobe", 32'(write_audio_out), 32'd1);
    chk("left_data", left, exp);
    chk("right_data", right, exp);
    step();
    chk("gap_no_write", 32'(write_audio_out), 32'd0);
    chk("gap_hold", left, exp);
    step();
    chk("idle_no_write", 32'(write_audio_out), 32'd0);
    step();
  endtask

  task automatic tick_val(input logic [31:0] v);
    mix_down = v;
    sample_tick = 1;
    step();
    sample_tick = 0;
  endtask

  function automatic logic [31:0] q(input int v);
    return (32'(v) << 22) ^ 32'h8000_0000;
  endfunction

  initial begin
    vecs[0] = '{32'hC000_0000, 2'd0, 1'b0, 32'h4000_0000};
    vecs[1] = '{32'h0000_0000, 2'd1, 1'b0, 32'hC000_0000};
    vecs[2] = '{32'hC000_0000, 2'd2, 1'b0, 32'h1000_0000};
    vecs[3] = '{32'hC000_0000, 2'd0, 1'b1, 32'h0000_0000};
    vecs[4] = '{32'hFFFF_FFFF, 2'd3, 1'b0, 32'h0FFF_FFFF};
    vecs[5] = '{32'h0000_0000, 2'd3, 1'b0, 32'hF000_0000};
    vecs[6] = '{32'h0000_0000, 2'd2, 1'b1, 32'h0000_0000};
    vecs[7] = '{32'h8000_0000, 2'd0, 1'b0, 32'h0000_0000};
    mix_down = 0; volume = 0; mute = 0; audio_out_allowed = 1; sample_tick = 0;
    resetn = 0;
    step();
    step();
    chk("rst_left", left, 0);
    chk("rst_right", right, 0);
    chk("rst_write", 32'(write_audio_out), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_overflow", 32'(overflow), 0);
    resetn = 1;
    step();

    for (int i = 0; i < 8; i++) begin
      volume = vecs[i].vol;
      mute = vecs[i].mute;
      tick_val(vecs[i].mix);
      chk("vec_level_n1", 32'(fifo_level), 1);
      chk("vec_no_write_n1", 32'(write_audio_out), 0);
      step();
      expect_write(vecs[i].exp);
      chk("vec_level_after", 32'(fifo_level), 0);
    end
    volume = 0; mute = 0;

    // Overflow: five ticks into a depth-4 FIFO with the codec stalled.
    do_reset();
    audio_out_allowed = 0;
    for (int v = 1; v <= 5; v++) tick_val(32'(v) << 22);
    step();
    chk("ovf_level", 32'(fifo_level), 4);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_no_write", 32'(write_audio_out), 0);
    audio_out_allowed = 1;
    step();
    for (int v = 1; v <= 4; v++) expect_write(q(v));
    chk("ovf_drained", 32'(fifo_level), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    step();
    chk("empty_no_write", 32'(write_audio_out), 0);

    // Full FIFO with a tick coincident with the pop.
    do_reset();
    audio_out_allowed = 0;
    for (int v = 1; v <= 4; v++) tick_val(32'(v) << 22);
    chk("full_level", 32'(fifo_level), 4);
    audio_out_allowed = 1;
    tick_val(32'd6 << 22);
    chk("pp_level", 32'(fifo_level), 4);
    chk("pp_overflow", 32'(overflow), 0);
    for (int v = 1; v <= 4; v++) expect_write(q(v));
    expect_write(q(6));
    chk("pp_overflow_end", 32'(overflow), 0);

    // Reset asserted during the WRITE cycle, with a coincident tick.
    do_reset();
    audio_out_allowed = 0;
    for (int v = 1; v <= 4; v++) tick_val(32'(v) << 22);
    audio_out_allowed = 1;
    step();
    chk("rw_write", 32'(write_audio_out), 1);
    chk("rw_level", 32'(fifo_level), 3);
    resetn = 0;
    mix_down = 32'hFFFF_FFFF;
    sample_tick = 1;
    step();
    resetn = 1;
    sample_tick = 0;
    chk("rw_after_write", 32'(write_audio_out), 0);
    chk("rw_after_level", 32'(fifo_level), 0);
    chk("rw_after_overflow", 32'(overflow), 0);
    chk("rw_after_left", left, 0);
    chk("rw_after_right", right, 0);
    step();
    step();
    chk("rw_quiet", 32'(write_audio_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
